// File: rtl/i2c_arbitro_transacciones.sv
// i2c_arbitro_transacciones: round-robin owner of the shared I2C transaction
// generator. Requesters A and B are granted in turn. The winner's command is
// latched onto the generator inputs. End of transaction is detected when SCL
// has been idle-high for IDLE_CYC consecutive clk cycles.
// Optional build macro I2C_TIMEOUT_EN: abort with ERR when SCL never goes low
// within START_WAIT cycles after the start strobe.
module i2c_arbitro_transacciones #(
  parameter int IDLE_CYC   = 8,
  parameter int START_WAIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        REQ_A,
  input  logic        RNW_A,
  input  logic [6:0]  ADDR_A,
  input  logic [15:0] WR_DATA_A,
  output logic        GNT_A,
  output logic        DONE_A,
  output logic [15:0] RD_DATA_A,
  input  logic        REQ_B,
  input  logic        RNW_B,
  input  logic [6:0]  ADDR_B,
  input  logic [15:0] WR_DATA_B,
  output logic        GNT_B,
  output logic        DONE_B,
  output logic [15:0] RD_DATA_B,
  output logic        START_STB,
  output logic        RNW,
  output logic [6:0]  I2C_ADDR,
  output logic [15:0] WR_DATA,
  input  logic        SCL,
  input  logic [15:0] RD_DATA_GEN,
  output logic        BUSY,
  output logic        ERR
);

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    LANZAR   = 3'd1,
    ESPERA   = 3'd2,
    EN_CURSO = 3'd3,
    FIN      = 3'd4
  } t_estado;

  // Counters must hold the larger of the two limits; SCL high phase is 2 clk.
  localparam int CNT_NEED = (IDLE_CYC > START_WAIT) ? IDLE_CYC : START_WAIT;
  localparam logic [CNT_W-1:0] ALTO_FIN = CNT_W'(IDLE_CYC - 1);

  if (IDLE_CYC <= 2 || CNT_NEED > (2 ** CNT_W) - 1) begin : g_param_invalido
    $error("i2c_arbitro_transacciones: IDLE_CYC must exceed 2 and CNT_W must hold max(IDLE_CYC, START_WAIT)");
  end

  t_estado          r_state;
  t_estado          w_next;
  logic             r_last_b;    // 1: B was served last, so A wins a tie
  logic             r_owner_b;   // requester that owns the current transaction
  logic [CNT_W-1:0] r_alto_cnt;  // consecutive SCL-high cycles in EN_CURSO
  logic             w_win_b;
  logic             w_timeout;

  // B wins when it is alone, or on a tie when A was served last
  assign w_win_b = REQ_B & (~REQ_A | ~r_last_b);

`ifdef I2C_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ESP_FIN = CNT_W'(START_WAIT - 1);
  logic [CNT_W-1:0] r_esp_cnt;   // cycles spent in ESPERA

  // Start-wait counter: runs only while waiting for the first SCL low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_esp_cnt <= '0;
    end else if (r_state == ESPERA) begin
      r_esp_cnt <= r_esp_cnt + 1'b1;
    end else begin
      r_esp_cnt <= '0;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      REPOSO:   if (REQ_A || REQ_B) w_next = LANZAR;
      LANZAR:   w_next = ESPERA;
      ESPERA: begin
        if (!SCL) begin
          w_next = EN_CURSO;
        end
`ifdef I2C_TIMEOUT_EN
        else if (r_esp_cnt == ESP_FIN) begin
          w_next    = FIN;
          w_timeout = 1'b1;
        end
`endif
      end
      EN_CURSO: if (SCL && r_alto_cnt == ALTO_FIN) w_next = FIN;
      FIN:      w_next = REPOSO;
      default:  w_next = REPOSO;
    endcase
  end

  // State register, idle-high counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= REPOSO;
      r_last_b   <= 1'b1;
      r_owner_b  <= 1'b0;
      r_alto_cnt <= '0;
      GNT_A      <= 1'b0;
      GNT_B      <= 1'b0;
      DONE_A     <= 1'b0;
      DONE_B     <= 1'b0;
      RD_DATA_A  <= '0;
      RD_DATA_B  <= '0;
      START_STB  <= 1'b0;
      RNW        <= 1'b0;
      I2C_ADDR   <= '0;
      WR_DATA    <= '0;
      BUSY       <= 1'b0;
`ifdef I2C_TIMEOUT_EN
      ERR        <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
      START_STB <= (r_state == LANZAR);
      BUSY      <= (w_next != REPOSO);
      DONE_A    <= 1'b0;
      DONE_B    <= 1'b0;
`ifdef I2C_TIMEOUT_EN
      ERR       <= 1'b0;
`endif

      if (r_state == ESPERA) begin
        r_alto_cnt <= '0;
      end else if (r_state == EN_CURSO) begin
        r_alto_cnt <= SCL ? r_alto_cnt + 1'b1 : '0;
      end

      // Grant: latch the winner's command; it stays frozen until FIN
      if (r_state == REPOSO && w_next == LANZAR) begin
        r_owner_b <= w_win_b;
        GNT_A     <= ~w_win_b;
        GNT_B     <= w_win_b;
        RNW       <= w_win_b ? RNW_B     : RNW_A;
        I2C_ADDR  <= w_win_b ? ADDR_B    : ADDR_A;
        WR_DATA   <= w_win_b ? WR_DATA_B : WR_DATA_A;
      end

      // Completion: pulse DONE to the owner, return read data unless aborted
      if (w_next == FIN) begin
        GNT_A    <= 1'b0;
        GNT_B    <= 1'b0;
        DONE_A   <= ~r_owner_b;
        DONE_B   <= r_owner_b;
        r_last_b <= r_owner_b;
`ifdef I2C_TIMEOUT_EN
        ERR      <= w_timeout;
`endif
        if (RNW && !w_timeout) begin
          if (r_owner_b) RD_DATA_B <= RD_DATA_GEN;
          else           RD_DATA_A <= RD_DATA_GEN;
        end
      end
    end
  end

`ifndef I2C_TIMEOUT_EN
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_arbitro_transacciones.sv
// Directed bench for i2c_arbitro_transacciones: writes, reads, round-robin
// ties, command stability, mid-transaction reset and start-wait behaviour.
module tb_i2c_arbitro_transacciones;

  logic        clk;
  logic        rst;
  logic        REQ_A, RNW_A, REQ_B, RNW_B;
  logic [6:0]  ADDR_A, ADDR_B;
  logic [15:0] WR_DATA_A, WR_DATA_B;
  logic        GNT_A, DONE_A, GNT_B, DONE_B;
  logic [15:0] RD_DATA_A, RD_DATA_B;
  logic        START_STB, RNW, SCL, BUSY, ERR;
  logic [6:0]  I2C_ADDR;
  logic [15:0] WR_DATA, RD_DATA_GEN;

  int n_vec = 0;
  int n_bad = 0;

  i2c_arbitro_transacciones dut (
    .clk(clk), .rst(rst),
    .REQ_A(REQ_A), .RNW_A(RNW_A), .ADDR_A(ADDR_A), .WR_DATA_A(WR_DATA_A),
    .GNT_A(GNT_A), .DONE_A(DONE_A), .RD_DATA_A(RD_DATA_A),
    .REQ_B(REQ_B), .RNW_B(RNW_B), .ADDR_B(ADDR_B), .WR_DATA_B(WR_DATA_B),
    .GNT_B(GNT_B), .DONE_B(DONE_B), .RD_DATA_B(RD_DATA_B),
    .START_STB(START_STB), .RNW(RNW), .I2C_ADDR(I2C_ADDR), .WR_DATA(WR_DATA),
    .SCL(SCL), .RD_DATA_GEN(RD_DATA_GEN), .BUSY(BUSY), .ERR(ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from the granting edge to the DONE pulse.
  // SCL is driven as clk/4 (2 low, 2 high) for nper periods, then held high.
  task automatic run_txn(input logic exp_b, input logic [6:0] exp_addr,
                         input logic [15:0] exp_wr, input logic exp_rnw,
                         input int nper, input logic disturb,
                         input logic [15:0] exp_rd_a, input logic [15:0] exp_rd_b);
    tick();
    chk1("grant_a", GNT_A, ~exp_b);
    chk1("grant_b", GNT_B, exp_b);
    chk1("busy_grant", BUSY, 1'b1);
    chk1("stb_early", START_STB, 1'b0);
    chk7("addr_grant", I2C_ADDR, exp_addr);
    chk16("wr_grant", WR_DATA, exp_wr);
    chk1("rnw_grant", RNW, exp_rnw);
    tick();
    chk1("stb_pulse", START_STB, 1'b1);
    tick();
    chk1("stb_end", START_STB, 1'b0);
    for (int p = 0; p < nper; p++) begin
      SCL = 1'b0; tick(); tick();
      SCL = 1'b1; tick(); tick();
      if (disturb && p == 1) begin
        ADDR_A    = 7'h11;
        WR_DATA_A = 16'h0000;
      end
      chk7("addr_hold", I2C_ADDR, exp_addr);
      chk16("wr_hold", WR_DATA, exp_wr);
      chk1("rnw_hold", RNW, exp_rnw);
      chk1("done_early", DONE_A | DONE_B, 1'b0);
      chk1("gnt_excl", GNT_A & GNT_B, 1'b0);
    end
    // Two high cycles already seen; five more must not complete the transfer
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("done_idle_hi", DONE_A | DONE_B, 1'b0);
    end
    tick();
    chk1("done_a", DONE_A, ~exp_b);
    chk1("done_b", DONE_B, exp_b);
    chk1("gnt_a_fin", GNT_A, 1'b0);
    chk1("gnt_b_fin", GNT_B, 1'b0);
    chk1("busy_fin", BUSY, 1'b1);
    chk1("err_fin", ERR, 1'b0);
    chk7("addr_fin", I2C_ADDR, exp_addr);
    chk16("rd_a_fin", RD_DATA_A, exp_rd_a);
    chk16("rd_b_fin", RD_DATA_B, exp_rd_b);
  endtask

  initial begin
    logic seen_done;
    logic busy_drop;

    rst = 1'b1; SCL = 1'b1; RD_DATA_GEN = 16'h1357;
    REQ_A = 1'b0; RNW_A = 1'b0; ADDR_A = 7'h00; WR_DATA_A = 16'h0000;
    REQ_B = 1'b0; RNW_B = 1'b0; ADDR_B = 7'h00; WR_DATA_B = 16'h0000;
    tick();
    chk1("rst_gnt_a", GNT_A, 1'b0);
    chk1("rst_gnt_b", GNT_B, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_stb", START_STB, 1'b0);
    chk1("rst_err", ERR, 1'b0);
    chk7("rst_addr", I2C_ADDR, 7'h00);
    chk16("rst_wr", WR_DATA, 16'h0000);
    chk16("rst_rd_a", RD_DATA_A, 16'h0000);
    rst = 1'b0;

    // Write A with the command inputs disturbed mid-transfer
    REQ_A = 1'b1; RNW_A = 1'b0; ADDR_A = 7'h2A; WR_DATA_A = 16'hA55A;
    run_txn(1'b0, 7'h2A, 16'hA55A, 1'b0, 29, 1'b1, 16'h0000, 16'h0000);
    REQ_A = 1'b0; ADDR_A = 7'h2A; WR_DATA_A = 16'hA55A;
    tick();
    chk1("wr_a_done_end", DONE_A, 1'b0);
    chk1("wr_a_busy_end", BUSY, 1'b0);
    tick();
    chk1("wr_a_no_regrant", GNT_A, 1'b0);

    // Read B
    REQ_B = 1'b1; RNW_B = 1'b1; ADDR_B = 7'h50; WR_DATA_B = 16'h1234;
    RD_DATA_GEN = 16'hBEEF;
    run_txn(1'b1, 7'h50, 16'h1234, 1'b1, 3, 1'b0, 16'h0000, 16'hBEEF);
    REQ_B = 1'b0;
    tick();
    chk1("rd_b_done_end", DONE_B, 1'b0);
    chk16("rd_b_hold", RD_DATA_B, 16'hBEEF);

    // Tie after reset: A first, then alternating, one idle cycle between
    rst = 1'b1;
    REQ_A = 1'b1; RNW_A = 1'b0; ADDR_A = 7'h33; WR_DATA_A = 16'h1111;
    REQ_B = 1'b1; RNW_B = 1'b0; ADDR_B = 7'h44; WR_DATA_B = 16'h2222;
    tick();
    chk16("rst2_rd_b", RD_DATA_B, 16'h0000);
    chk1("rst2_gnt_a", GNT_A, 1'b0);
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) run_txn(1'b0, 7'h33, 16'h1111, 1'b0, 2, 1'b0, 16'h0000, 16'h0000);
      else            run_txn(1'b1, 7'h44, 16'h2222, 1'b0, 2, 1'b0, 16'h0000, 16'h0000);
      tick();
      chk1("rr_idle_busy", BUSY, 1'b0);
      chk1("rr_idle_gnt", GNT_A | GNT_B, 1'b0);
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();

    // Reset during EN_CURSO, then a fresh B request
    REQ_A = 1'b1; RNW_A = 1'b1; ADDR_A = 7'h2A; WR_DATA_A = 16'hA55A;
    RD_DATA_GEN = 16'hDEAD;
    tick(); tick(); tick();
    SCL = 1'b0; tick(); tick();
    SCL = 1'b1; tick();
    chk1("pre_rst_gnt", GNT_A, 1'b1);
    rst = 1'b1;
    tick();
    chk1("mrst_gnt_a", GNT_A, 1'b0);
    chk1("mrst_busy", BUSY, 1'b0);
    chk1("mrst_done", DONE_A | DONE_B, 1'b0);
    chk1("mrst_rnw", RNW, 1'b0);
    chk7("mrst_addr", I2C_ADDR, 7'h00);
    chk16("mrst_wr", WR_DATA, 16'h0000);
    chk16("mrst_rd_a", RD_DATA_A, 16'h0000);
    rst = 1'b0; REQ_A = 1'b0;
    REQ_B = 1'b1; RNW_B = 1'b1; ADDR_B = 7'h50; WR_DATA_B = 16'h0F0F;
    RD_DATA_GEN = 16'h7E57;
    run_txn(1'b1, 7'h50, 16'h0F0F, 1'b1, 2, 1'b0, 16'h0000, 16'h7E57);
    REQ_B = 1'b0;
    tick();
    tick();

    // SCL stuck high after the start strobe
    REQ_A = 1'b1; RNW_A = 1'b1; ADDR_A = 7'h2A; WR_DATA_A = 16'hA55A;
    RD_DATA_GEN = 16'hCAFE; SCL = 1'b1;
    tick();
    chk1("to_grant", GNT_A, 1'b1);
    tick();
    chk1("to_stb", START_STB, 1'b1);
`ifdef I2C_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk1("to_done_early", DONE_A, 1'b0);
    end
    tick();
    chk1("to_done", DONE_A, 1'b1);
    chk1("to_err", ERR, 1'b1);
    chk16("to_rd_a", RD_DATA_A, 16'h0000);
    REQ_A = 1'b0;
    tick();
    chk1("to_err_end", ERR, 1'b0);
    chk1("to_done_end", DONE_A, 1'b0);
`else
    seen_done = 1'b0;
    busy_drop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (DONE_A || DONE_B) seen_done = 1'b1;
      if (!BUSY) busy_drop = 1'b1;
    end
    chk1("stuck_no_done", seen_done, 1'b0);
    chk1("stuck_busy_kept", busy_drop, 1'b0);
    chk1("stuck_err", ERR, 1'b0);
    chk16("stuck_rd_a", RD_DATA_A, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
